// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-serial program image loader driving the core's program-memory write port
// Optional running checksum built only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
   parameter int ADDWIDTH    = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                loadReq,
   input  logic                byteStrobe,
   input  logic [7:0]          byteIn,
   output logic                pmWrEn,
   output logic [ADDWIDTH-1:0] pmAddr,
   output logic [7:0]          instructionIn,
   output logic                cpuRst,
   output logic                loading,
   output logic                overflow,
   output logic [7:0]          checksum
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   localparam logic [ADDWIDTH:0] CNT_ONE = 1;

   logic [SYNC_STAGES-1:0] loadSync;
   logic [SYNC_STAGES-1:0] strobeSync;
   logic                   strobeDly;
   logic                   loadReqS;
   logic                   strobeRise;

   logic [1:0]        state;
   logic [1:0]        nextState;
   logic [ADDWIDTH:0] cnt;
   logic [7:0]        hold;
   logic              pending;
   logic              accept;
   logic              full;
   logic              enterLoad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loadSync   <= '0;
         strobeSync <= '0;
         strobeDly  <= 1'b0;
      end else begin
         loadSync   <= {loadSync[SYNC_STAGES-2:0], loadReq};
         strobeSync <= {strobeSync[SYNC_STAGES-2:0], byteStrobe};
         strobeDly  <= strobeSync[SYNC_STAGES-1];
      end
   end

   assign loadReqS   = loadSync[SYNC_STAGES-1];
   assign strobeRise = strobeSync[SYNC_STAGES-1] & ~strobeDly;

   // The top counter bit marks "memory full"; a strobe then only raises overflow.
   always_comb begin
      accept    = (state == LOAD) && strobeRise && !cnt[ADDWIDTH];
      full      = (state == LOAD) && strobeRise && cnt[ADDWIDTH];
      enterLoad = (state != LOAD) && loadReqS;
      nextState = state;
      case (state)
         IDLE: if (loadReqS) nextState = LOAD;
         // Leaving LOAD waits for any accepted byte to be written first.
         LOAD: if (!loadReqS && !pending && !accept) nextState = RUN;
         RUN:  if (loadReqS) nextState = LOAD;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         hold          <= 8'h00;
         pending       <= 1'b0;
         pmWrEn        <= 1'b0;
         pmAddr        <= '0;
         instructionIn <= 8'h00;
         cpuRst        <= 1'b1;
         loading       <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         state   <= nextState;
         cpuRst  <= (nextState != RUN);
         loading <= (nextState == LOAD);
         pending <= accept;
         pmWrEn  <= pending;
         if (accept) hold <= byteIn;
         if (pending) begin
            pmAddr        <= cnt[ADDWIDTH-1:0];
            instructionIn <= hold;
         end
         if (enterLoad) begin
            cnt      <= '0;
            overflow <= 1'b0;
         end else begin
            if (pending) cnt <= cnt + CNT_ONE;
            if (full) overflow <= 1'b1;
         end
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum <= 8'h00;
      end else if (enterLoad) begin
         checksum <= 8'h00;
      end else if (pending) begin
         checksum <= checksum + hold;
      end
   end
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed bench for program_loader
// Checksum expectations follow PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       loadReq = 1'b0;
   logic       byteStrobe = 1'b0;
   logic [7:0] byteIn = 8'h00;
   logic       pmWrEn;
   logic [6:0] pmAddr;
   logic [7:0] instructionIn;
   logic       cpuRst;
   logic       loading;
   logic       overflow;
   logic [7:0] checksum;

   program_loader #(.ADDWIDTH(7), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .loadReq(loadReq), .byteStrobe(byteStrobe), .byteIn(byteIn),
      .pmWrEn(pmWrEn), .pmAddr(pmAddr), .instructionIn(instructionIn), .cpuRst(cpuRst),
      .loading(loading), .overflow(overflow), .checksum(checksum)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       expWr;
      logic [6:0] expAddr;
   } vec_t;

   int   total = 0;
   int   passed = 0;
   logic [6:0] wrAddr[$];
   logic [7:0] wrData[$];

   always @(negedge clk) begin
      if (pmWrEn) begin
         wrAddr.push_back(pmAddr);
         wrData.push_back(instructionIn);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic sendByte(input logic [7:0] b);
      byteIn = b;
      byteStrobe = 1'b1;
      ticks(4);
      byteStrobe = 1'b0;
      ticks(4);
   endtask

   vec_t vecs[2];
   logic [7:0] expSum;
   int         n0;
   int         bad;

   initial begin
      vecs[0] = '{data: 8'h05, expWr: 1'b1, expAddr: 7'd1};
      vecs[1] = '{data: 8'hFF, expWr: 1'b1, expAddr: 7'd2};

      // Reset values
      ticks(2);
      chk("rst_pmWrEn", pmWrEn, 0);
      chk("rst_pmAddr", pmAddr, 0);
      chk("rst_instr", instructionIn, 0);
      chk("rst_cpuRst", cpuRst, 1);
      chk("rst_loading", loading, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_checksum", checksum, 0);
      rst = 1'b0;
      ticks(2);

      // Strobe in IDLE is ignored
      sendByte(8'hAA);
      chk("idle_nowrite", wrAddr.size(), 0);
      chk("idle_cpuRst", cpuRst, 1);
      chk("idle_loading", loading, 0);

      loadReq = 1'b1;
      ticks(4);
      chk("load_loading", loading, 1);
      chk("load_cpuRst", cpuRst, 1);

      // Latency: rise sampled at edge k, pmWrEn in the cycle after edge k+3
      byteIn = 8'h13;
      byteStrobe = 1'b1;
      tick();
      chk("lat_k0", pmWrEn, 0);
      tick();
      chk("lat_k1", pmWrEn, 0);
      tick();
      chk("lat_k2", pmWrEn, 0);
      tick();
      chk("lat_k3", pmWrEn, 1);
      chk("lat_addr", pmAddr, 0);
      chk("lat_data", instructionIn, 8'h13);
      chk("lat_loading", loading, 1);
      byteStrobe = 1'b0;
      tick();
      chk("lat_k4", pmWrEn, 0);
      ticks(4);
      chk("lat_count", wrAddr.size(), 1);

      // Table-driven remainder of the basic load
      for (int i = 0; i < 2; i++) begin
         n0 = wrAddr.size();
         sendByte(vecs[i].data);
         chk($sformatf("vec%0d_count", i), wrAddr.size(), n0 + int'(vecs[i].expWr));
         if (vecs[i].expWr && wrAddr.size() > n0) begin
            chk($sformatf("vec%0d_addr", i), wrAddr[wrAddr.size()-1], vecs[i].expAddr);
            chk($sformatf("vec%0d_data", i), wrData[wrData.size()-1], vecs[i].data);
         end
         chk($sformatf("vec%0d_loading", i), loading, 1);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      expSum = 8'h17;
`else
      expSum = 8'h00;
`endif
      chk("basic_checksum", checksum, expSum);

      // loadReq fall: cpuRst falls on the third edge
      loadReq = 1'b0;
      tick();
      chk("end_e1_cpuRst", cpuRst, 1);
      tick();
      chk("end_e2_cpuRst", cpuRst, 1);
      tick();
      chk("end_e3_cpuRst", cpuRst, 0);
      chk("end_e3_loading", loading, 0);

      // Strobe in RUN is ignored
      n0 = wrAddr.size();
      sendByte(8'h77);
      chk("run_nowrite", wrAddr.size(), n0);
      chk("run_cpuRst", cpuRst, 0);

      // Memory full
      loadReq = 1'b1;
      ticks(4);
      wrAddr.delete();
      wrData.delete();
      for (int i = 0; i < 128; i++) sendByte(8'(i) ^ 8'h5A);
      bad = 0;
      if (wrAddr.size() == 128) begin
         for (int i = 0; i < 128; i++)
            if (wrAddr[i] !== 7'(i) || wrData[i] !== (8'(i) ^ 8'h5A)) bad++;
      end else begin
         bad = -1;
      end
      chk("full_128_writes", bad, 0);
      chk("full_ovf_before", overflow, 0);
      sendByte(8'hEE);
      chk("full_129_nowrite", wrAddr.size(), 128);
      chk("full_ovf_set", overflow, 1);
      loadReq = 1'b0;
      ticks(5);
      chk("full_ovf_sticky", overflow, 1);
      loadReq = 1'b1;
      ticks(4);
      chk("full_ovf_cleared", overflow, 0);
      chk("full_reentry_checksum", checksum, 0);

      // Simultaneous strobe rise and loadReq fall
      wrAddr.delete();
      wrData.delete();
      byteIn = 8'h3C;
      byteStrobe = 1'b1;
      loadReq = 1'b0;
      ticks(3);
      chk("sim_k2_wr", pmWrEn, 0);
      chk("sim_k2_cpuRst", cpuRst, 1);
      tick();
      chk("sim_k3_wr", pmWrEn, 1);
      chk("sim_k3_cpuRst", cpuRst, 1);
      chk("sim_k3_addr", pmAddr, 0);
      chk("sim_k3_data", instructionIn, 8'h3C);
      tick();
      chk("sim_k4_wr", pmWrEn, 0);
      chk("sim_k4_cpuRst", cpuRst, 0);
      byteStrobe = 1'b0;
      ticks(4);
      chk("sim_count", wrAddr.size(), 1);

      // Reset between byte 2's strobeRise and its write
      loadReq = 1'b1;
      ticks(4);
      wrAddr.delete();
      wrData.delete();
      sendByte(8'h11);
      byteIn = 8'h22;
      byteStrobe = 1'b1;
      ticks(3);
      rst = 1'b1;
      #1;
      chk("mid_rst_wr", pmWrEn, 0);
      chk("mid_rst_addr", pmAddr, 0);
      chk("mid_rst_instr", instructionIn, 0);
      chk("mid_rst_cpuRst", cpuRst, 1);
      chk("mid_rst_loading", loading, 0);
      byteStrobe = 1'b0;
      ticks(3);
      chk("mid_rst_count", wrAddr.size(), 1);
      rst = 1'b0;
      ticks(4);
      chk("mid_reload_loading", loading, 1);
      sendByte(8'h33);
      chk("mid_reload_count", wrAddr.size(), 2);
      if (wrAddr.size() == 2) begin
         chk("mid_reload_addr", wrAddr[1], 0);
         chk("mid_reload_data", wrData[1], 8'h33);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
